// File: rtl/aes_pkg.sv
// Shared AES helpers for the decryption key prep path.
// Round constants, S-box, word ops and FSM states.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse; maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_dec_key_prep_if.sv
// Key handshake and round-key-10 result bundle.
// master = key source side, slave = key prep block.
interface aes_dec_key_prep_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         flush;
  logic [127:0] round_key_10;
  logic         rk_valid;
  logic         rk_done;
  logic         busy;

  modport master (
    output key_in, key_valid, flush,
    input  key_ready, round_key_10, rk_valid, rk_done, busy
  );

  modport slave (
    input  key_in, key_valid, flush,
    output key_ready, round_key_10, rk_valid, rk_done, busy
  );
endinterface

// File: rtl/aes_fwd_key_round.sv
// One forward AES-128 key expansion round.
// Purely combinational: key for round rnd-1 -> key for rnd.
module aes_fwd_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   rnd,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w4, w5, w6, w7;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign w4 = w0
    ^ sub_word(rot_word(w3))
    ^ {rcon(rnd), 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/aes_dec_key_prep.sv
// Walks the forward key schedule to round key 10,
// with a one-entry cache to skip repeat expansions.
module aes_dec_key_prep
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input logic clk,
  input logic rst,
  aes_dec_key_prep_if.slave kp
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state;
  logic [127:0] work;
  logic [127:0] cached_key;
  logic         cache_vld;
  logic [3:0]   rnd;
  logic [127:0] rk_q;
  logic         rk_valid_q;
  logic         rk_done_q;
  logic [127:0] next_key;
  logic         ready;
  logic         hit;

  aes_fwd_key_round u_round (
    .key      (work),
    .rnd      (rnd),
    .next_key (next_key)
  );

  assign ready = (state != EXPAND);
  assign hit   = cache_vld && (kp.key_in == cached_key);

  assign kp.key_ready    = ready;
  assign kp.busy         = (state == EXPAND);
  assign kp.round_key_10 = rk_q;
  assign kp.rk_valid     = rk_valid_q;
  assign kp.rk_done      = rk_done_q;

  // FSM, round counter, cache and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      work       <= '0;
      cached_key <= '0;
      cache_vld  <= 1'b0;
      rnd        <= 4'd0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
      rk_done_q  <= 1'b0;
    end else begin
      rk_done_q <= 1'b0;
      if (kp.flush) begin
        state      <= IDLE;
        work       <= '0;
        cached_key <= '0;
        cache_vld  <= 1'b0;
        rk_q       <= '0;
        rk_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (kp.key_valid && ready) begin
              if (hit) begin
                state      <= DONE;
                rk_valid_q <= 1'b1;
                rk_done_q  <= 1'b1;
              end else begin
                work       <= kp.key_in;
                cached_key <= kp.key_in;
                rnd        <= 4'd1;
                cache_vld  <= 1'b0;
                rk_valid_q <= 1'b0;
                state      <= EXPAND;
              end
            end
          end
          EXPAND: begin
            work <= next_key;
            if (rnd == LAST) begin
              rk_q       <= next_key;
              cache_vld  <= 1'b1;
              rk_valid_q <= 1'b1;
              rk_done_q  <= 1'b1;
              state      <= DONE;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_key_prep.sv
// Bench for aes_dec_key_prep: FIPS vectors plus random
// keys against a word-array key schedule model.
module tb_aes_dec_key_prep;

  logic clk = 1'b0;
  logic rst = 1'b1;

  aes_dec_key_prep_if kp ();

  aes_dec_key_prep #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] mc_key;
  bit           mc_vld;
  logic [127:0] last_rk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(
    input logic [7:0] a_in,
    input logic [7:0] b
  );
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? (8'(a << 1) ^ 8'h1b) : 8'(a << 1);
    end
    return p;
  endfunction

  // Inverse found by search, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv
        ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_rk(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge rk_done is seen.
  task automatic run_key(
    input logic [127:0] k,
    input bit           glitch,
    input string        tag
  );
    bit           hit;
    int           exp_e;
    logic [127:0] exp_rk;
    logic [127:0] old;
    int           e;
    int           low;
    int           bsy;
    hit    = mc_vld && (k == mc_key);
    exp_e  = hit ? 0 : 10;
    exp_rk = hit ? last_rk : ref_rk(k);
    old    = last_rk;
    chk({tag, "_ready_in"}, 128'(kp.key_ready), 128'(1));
    kp.key_in    = k;
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    if (!hit) begin
      chk({tag, "_drop_vld"}, 128'(kp.rk_valid), 128'(0));
      chk({tag, "_hold_rk"}, kp.round_key_10, old);
    end
    e = 0; low = 0; bsy = 0;
    while (!kp.rk_done && e < 20) begin
      if (!kp.key_ready) low++;
      if (kp.busy) bsy++;
      if (glitch && e == 3) begin
        kp.key_in    = rnd128();
        kp.key_valid = 1'b1;
      end
      if (glitch && e == 4) kp.key_valid = 1'b0;
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, 128'(e), 128'(exp_e));
    chk({tag, "_ready_low"}, 128'(low), 128'(exp_e));
    chk({tag, "_busy_cyc"}, 128'(bsy), 128'(exp_e));
    chk({tag, "_rk"}, kp.round_key_10, exp_rk);
    chk({tag, "_rk_valid"}, 128'(kp.rk_valid), 128'(1));
    last_rk = exp_rk;
    mc_key  = k;
    mc_vld  = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rk"}, kp.round_key_10, '0);
    chk({tag, "_rk_valid"}, 128'(kp.rk_valid), 128'(0));
    chk({tag, "_rk_done"}, 128'(kp.rk_done), 128'(0));
    chk({tag, "_busy"}, 128'(kp.busy), 128'(0));
    chk({tag, "_ready"}, 128'(kp.key_ready), 128'(1));
  endtask

  localparam logic [127:0] FIPS_K  =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK =
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_K   =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK  =
    128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ZERO_RK =
    128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    logic [127:0] k;
    int e;
    kp.key_in    = '0;
    kp.key_valid = 1'b0;
    kp.flush     = 1'b0;
    mc_vld  = 1'b0;
    mc_key  = '0;
    last_rk = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    run_key(FIPS_K, 1'b0, "fips");
    chk("fips_vec", kp.round_key_10, FIPS_RK);
    run_key(FIPS_K, 1'b0, "hit");
    chk("hit_vec", kp.round_key_10, FIPS_RK);

    run_key(SEQ_K, 1'b0, "seq");
    chk("seq_vec", kp.round_key_10, SEQ_RK);
    run_key('0, 1'b0, "zero");
    chk("zero_vec", kp.round_key_10, ZERO_RK);

    for (int i = 0; i < 4; i++) begin
      k = rnd128();
      run_key(k, (i % 2) == 1, $sformatf("rand%0d", i));
      if (i == 3) run_key(k, 1'b0, "rand_hit");
    end

    kp.flush = 1'b1;
    @(negedge clk);
    kp.flush = 1'b0;
    chk_idle("flush");
    mc_vld  = 1'b0;
    last_rk = '0;
    run_key(FIPS_K, 1'b0, "reload");
    chk("reload_vec", kp.round_key_10, FIPS_RK);

    kp.flush     = 1'b1;
    kp.key_in    = SEQ_K;
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.flush     = 1'b0;
    kp.key_valid = 1'b0;
    chk_idle("flush_pri");
    mc_vld  = 1'b0;
    last_rk = '0;
    repeat (3) @(negedge clk);
    chk("flush_pri_busy", 128'(kp.busy), 128'(0));
    chk("flush_pri_vld", 128'(kp.rk_valid), 128'(0));

    kp.key_in    = FIPS_K;
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
    e = 0;
    while (e < 4) begin
      @(negedge clk);
      e++;
    end
    chk("mid_busy", 128'(kp.busy), 128'(1));
    rst = 1'b1;
    #1;
    chk_idle("mid_rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("mid_rst");
    mc_vld  = 1'b0;
    last_rk = '0;
    run_key(FIPS_K, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
